// File: rtl/lcd_capture.sv
// ----------------------------------------------------------------------------
// lcd_capture
// Captures the DMG LCD pixel stream (2-bit shades) and packs four pixels per
// byte into a 160x144 framebuffer (40 bytes per line, 5760 bytes per bank).
//
// Ports
//   clk         in   system clock, all registers on posedge
//   rst         in   synchronous, active-low reset
//   cap_en      in   capture enable, sampled on frame-start vsync edges
//   lcd_vsync   in   frame sync, rising edge = end of frame
//   lcd_hsync   in   line sync, rising edge = end of line
//   lcd_pixel   in   pixel strobe, lcd_color valid this cycle
//   lcd_color   in   shade 0..3
//   err_clr     in   clears sticky error flags
//   fb_addr     out  byte address, bit 13 = bank
//   fb_data     out  packed byte, first pixel in [7:6]
//   fb_we       out  one-cycle write strobe
//   frame_done  out  one-cycle pulse after a captured frame ends
//   front_bank  out  bank holding the last completed frame
//   err_line    out  sticky: line length != 160 or pixel beyond x=159
//   err_frame   out  sticky: frame height != 144 or pixel beyond y=143
//
// Build option
//   LCD_CAPTURE_DBUF_EN  double buffering: writes go to bank !front_bank and
//                        front_bank flips per completed frame. Without it
//                        bank and front_bank are constant 0.
//
// state     | meaning
// SYNC_WAIT | idle, pixels and hsync ignored, waiting for vsync with cap_en
// ACTIVE    | capturing pixels of the current frame
// ----------------------------------------------------------------------------
module lcd_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic        lcd_vsync,
    input  logic        lcd_hsync,
    input  logic        lcd_pixel,
    input  logic [1:0]  lcd_color,
    input  logic        err_clr,
    output logic [13:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_we,
    output logic        frame_done,
    output logic        front_bank,
    output logic        err_line,
    output logic        err_frame
);

    typedef enum logic {SYNC_WAIT, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic        vsync_q, hsync_q;
    logic [7:0]  x_q, x_d, y_q, y_d, pack_q, pack_d;
    logic [13:0] fb_addr_q, fb_addr_d;
    logic [7:0]  fb_data_q, fb_data_d;
    logic        fb_we_q, fb_we_d;
    logic        frame_done_q, frame_done_d;
    logic        front_bank_q, front_bank_d;
    logic        err_line_q, err_line_d, err_frame_q, err_frame_d;
    logic        line_err_set, frame_err_set;

    logic        vs_edge, hs_edge, pix_ok, wr_bank;
    logic [7:0]  x_eff, y_eff, pack_eff, flush_data;
    logic [12:0] line_base;

    assign vs_edge  = lcd_vsync & ~vsync_q;
    assign hs_edge  = lcd_hsync & ~hsync_q;
    assign pix_ok   = (x_q < 8'd160) && (y_q < 8'd144);
    // x and y saturate so an overlong line/frame can never wrap back into range
    assign x_eff    = (lcd_pixel && x_q != 8'hFF) ? x_q + 8'd1 : x_q;
    assign y_eff    = (hs_edge && y_q != 8'hFF) ? y_q + 8'd1 : y_q;
    assign pack_eff = (lcd_pixel && pix_ok) ? {pack_q[5:0], lcd_color} : pack_q;
    assign line_base = {5'd0, y_q} * 13'd40;

    // Partial group: keep only the pixels of this group, left-aligned
    always_comb begin
        case (x_eff[1:0])
            2'd1:    flush_data = {pack_eff[1:0], 6'd0};
            2'd2:    flush_data = {pack_eff[3:0], 4'd0};
            default: flush_data = {pack_eff[5:0], 2'd0};
        endcase
    end

`ifdef LCD_CAPTURE_DBUF_EN
    assign wr_bank = ~front_bank_q;
`else
    assign wr_bank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_q <= SYNC_WAIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC_WAIT: if (vs_edge && cap_en)  state_d = ACTIVE;
            ACTIVE:    if (vs_edge && !cap_en) state_d = SYNC_WAIT;
            default:   state_d = SYNC_WAIT;
        endcase
    end

    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        pack_d        = pack_q;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        frame_done_d  = 1'b0;
`ifdef LCD_CAPTURE_DBUF_EN
        front_bank_d  = front_bank_q;
`else
        front_bank_d  = 1'b0;
`endif
        line_err_set  = 1'b0;
        frame_err_set = 1'b0;

        if (state_q == SYNC_WAIT) begin
            if (vs_edge && cap_en) begin
                x_d    = 8'd0;
                y_d    = 8'd0;
                pack_d = 8'd0;
            end
        end else begin
            if (lcd_pixel) begin
                x_d    = x_eff;
                pack_d = pack_eff;
                if (!pix_ok) begin
                    line_err_set  = (x_q >= 8'd160);
                    frame_err_set = (y_q >= 8'd144);
                end else if (x_q[1:0] == 2'd3) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = {wr_bank, line_base + {7'd0, x_q[7:2]}};
                    fb_data_d = pack_eff;
                end
            end
            // Line end sees the x that already includes a same-cycle pixel;
            // a partial group never coincides with a full-group write.
            if (hs_edge) begin
                if (x_eff[1:0] != 2'd0 && x_eff < 8'd160 && y_q < 8'd144) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = {wr_bank, line_base + {7'd0, x_eff[7:2]}};
                    fb_data_d = flush_data;
                end
                if (x_eff != 8'd160) line_err_set = 1'b1;
                x_d = 8'd0;
                y_d = y_eff;
            end
            if (vs_edge) begin
                if (y_eff != 8'd144) frame_err_set = 1'b1;
                frame_done_d = 1'b1;
`ifdef LCD_CAPTURE_DBUF_EN
                front_bank_d = ~front_bank_q;
`endif
                x_d = 8'd0;
                y_d = 8'd0;
            end
        end

        err_line_d  = line_err_set  | (err_line_q  & ~err_clr);
        err_frame_d = frame_err_set | (err_frame_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vsync_q      <= 1'b0;
            hsync_q      <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            pack_q       <= 8'd0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= 14'd0;
            fb_data_q    <= 8'd0;
            frame_done_q <= 1'b0;
            front_bank_q <= 1'b0;
            err_line_q   <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            vsync_q      <= lcd_vsync;
            hsync_q      <= lcd_hsync;
            x_q          <= x_d;
            y_q          <= y_d;
            pack_q       <= pack_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            frame_done_q <= frame_done_d;
            front_bank_q <= front_bank_d;
            err_line_q   <= err_line_d;
            err_frame_q  <= err_frame_d;
        end
    end

    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign fb_we      = fb_we_q;
    assign frame_done = frame_done_q;
    assign front_bank = front_bank_q;
    assign err_line   = err_line_q;
    assign err_frame  = err_frame_q;

endmodule
